// File: rtl/sseg_scan_ctrl.sv
// sseg_scan_ctrl -- time-multiplexed seven-segment display scanner.
//
// Each digit owns one slot of 2**PRESC_W clocks. The first BLANK clocks of
// every slot are dark, which gives the anode drivers dead time between digits.
// Brightness is PWM: the top four bits of the slot counter are compared
// against 'bright'. New segment data is double-buffered. 'load' fills a
// pending buffer, and that buffer is copied into the display buffer only at a
// frame boundary, so a frame never mixes old and new data.
//
// Ports
//   clk         system clock, rising edge
//   reset_n     asynchronous active-low reset
//   seg_in      8*NDIG segment patterns, digit k at [8k+7:8k], bit 7 = dp
//   load        one-cycle strobe capturing seg_in
//   dig_en      per-digit enable, sampled live
//   bright      brightness 0 (dark) .. 15 (full), sampled live
//   an          one-hot digit enables (registered, polarity AN_ACT_LOW)
//   sseg        segment drive (registered, polarity SEG_ACT_LOW)
//   frame_tick  one-cycle pulse in the first cycle of each frame
module sseg_scan_ctrl #(
  parameter int NDIG        = 4,
  parameter int PRESC_W     = 16,
  parameter int BLANK       = 64,
  parameter int AN_ACT_LOW  = 0,
  parameter int SEG_ACT_LOW = 0
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [8*NDIG-1:0]   seg_in,
  input  logic                load,
  input  logic [NDIG-1:0]     dig_en,
  input  logic [3:0]          bright,
  output logic [NDIG-1:0]     an,
  output logic [7:0]          sseg,
  output logic                frame_tick
);

  localparam int DW = $clog2(NDIG);
  localparam logic [PRESC_W-1:0] CNT_MAX = '1;
  localparam logic [DW-1:0]      DIG_MAX = DW'(NDIG - 1);
  localparam logic [PRESC_W-1:0] BLANK_C = PRESC_W'(BLANK);
  localparam logic [NDIG-1:0]    AN_INACT  = (AN_ACT_LOW != 0) ? '1 : '0;
  localparam logic [7:0]         SEG_INACT = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;

  logic [PRESC_W-1:0] cnt_q, cnt_d;
  logic [DW-1:0]      dig_q, dig_d;
  logic [8*NDIG-1:0]  disp_q, disp_d;
  logic [8*NDIG-1:0]  pend_q, pend_d;
  logic               pend_vld_q, pend_vld_d;
  logic [NDIG-1:0]    an_q, an_d;
  logic [7:0]         sseg_q, sseg_d;
  logic               tick_q, tick_d;

  logic slot_end;
  logic boundary;
  logic lit;

  // Scan position: slot counter wraps naturally at 2**PRESC_W, the digit
  // index wraps explicitly because NDIG need not be a power of two.
  always_comb begin
    slot_end = (cnt_q == CNT_MAX);
    boundary = slot_end && (dig_q == DIG_MAX);
    cnt_d    = cnt_q + PRESC_W'(1);
    dig_d    = dig_q;
    if (slot_end) begin
      dig_d = (dig_q == DIG_MAX) ? '0 : dig_q + DW'(1);
    end
  end

  // Buffer update. A load landing on the boundary cycle bypasses the pending
  // buffer so the data appears in the very next slot.
  always_comb begin
    disp_d     = disp_q;
    pend_d     = pend_q;
    pend_vld_d = pend_vld_q;
    if (boundary) begin
      if (load) begin
        disp_d = seg_in;
      end else if (pend_vld_q) begin
        disp_d = pend_q;
      end
      pend_vld_d = 1'b0;
    end else if (load) begin
      pend_d     = seg_in;
      pend_vld_d = 1'b1;
    end
  end

  // Output decode from the current scan position. The result is registered,
  // so the pins see one clock of latency and never glitch.
  always_comb begin
    lit = dig_en[dig_q]
          && (cnt_q >= BLANK_C)
          && ((bright == 4'hF) || (cnt_q[PRESC_W-1 -: 4] < bright));
    an_d   = AN_INACT;
    sseg_d = SEG_INACT;
    if (lit) begin
      an_d   = (NDIG'(1) << dig_q) ^ AN_INACT;
      sseg_d = disp_q[{dig_q, 3'b000} +: 8] ^ SEG_INACT;
    end
    tick_d = boundary;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q      <= '0;
      dig_q      <= '0;
      disp_q     <= '0;
      pend_q     <= '0;
      pend_vld_q <= 1'b0;
      an_q       <= AN_INACT;
      sseg_q     <= SEG_INACT;
      tick_q     <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      dig_q      <= dig_d;
      disp_q     <= disp_d;
      pend_q     <= pend_d;
      pend_vld_q <= pend_vld_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      tick_q     <= tick_d;
    end
  end

  assign an         = an_q;
  assign sseg       = sseg_q;
  assign frame_tick = tick_q;

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Directed bench for sseg_scan_ctrl: NDIG=3, PRESC_W=6 (64-clock slots,
// 192-clock frames), BLANK=2. A second instance uses active-low polarity.
// 'cyc' counts rising edges since reset release; at the falling edge where
// cyc==s+1 the registered outputs reflect scan state s (cnt=s%64,
// dig=(s/64)%3).
module tb_sseg_scan_ctrl;

  logic        clk;
  logic        reset_n;
  logic [23:0] seg_in;
  logic        load;
  logic [2:0]  dig_en;
  logic [3:0]  bright;
  logic [2:0]  an0, an1;
  logic [7:0]  sseg0, sseg1;
  logic        tick0, tick1;

  int cyc;
  int n_assert;
  int n_fail;

  sseg_scan_ctrl #(
    .NDIG(3), .PRESC_W(6), .BLANK(2), .AN_ACT_LOW(0), .SEG_ACT_LOW(0)
  ) u0 (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .load(load),
    .dig_en(dig_en), .bright(bright), .an(an0), .sseg(sseg0),
    .frame_tick(tick0)
  );

  sseg_scan_ctrl #(
    .NDIG(3), .PRESC_W(6), .BLANK(2), .AN_ACT_LOW(1), .SEG_ACT_LOW(1)
  ) u1 (
    .clk(clk), .reset_n(reset_n), .seg_in(seg_in), .load(load),
    .dig_en(dig_en), .bright(bright), .an(an1), .sseg(sseg1),
    .frame_tick(tick1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) cyc <= 0;
    else          cyc <= cyc + 1;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance to the falling edge where cyc==n, bounded.
  task automatic goto_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc < n && guard < 5000) begin
      @(negedge clk);
      guard++;
    end
    chk("cycle_reached", cyc, n);
  endtask

  task automatic at_state(input int s);
    goto_cyc(s + 1);
  endtask

  initial begin
    n_assert = 0;
    n_fail   = 0;
    reset_n  = 1'b0;
    load     = 1'b0;
    bright   = 4'd15;
    dig_en   = 3'b111;
    seg_in   = {8'h06, 8'h5B, 8'h3F};

    // Reset levels for both polarities
    repeat (2) @(negedge clk);
    chk("rst_an",    an0,   3'b000);
    chk("rst_sseg",  sseg0, 8'h00);
    chk("rst_tick",  tick0, 1'b0);
    chk("rst_an_al", an1,   3'b111);
    chk("rst_seg_al", sseg1, 8'hFF);

    // Release and load initial data into pending buffer
    reset_n = 1'b1;
    load    = 1'b1;
    @(negedge clk);
    load    = 1'b0;

    // Before the first boundary the display buffer is still zero
    at_state(10);
    chk("pre_an",   an0,   3'b001);
    chk("pre_sseg", sseg0, 8'h00);
    at_state(190);
    chk("tick_190", tick0, 1'b0);
    at_state(191);
    chk("tick_191", tick0, 1'b1);

    // First frame with loaded data, full brightness
    at_state(192);
    chk("f1_blank0", an0, 3'b000);
    chk("f1_tick_off", tick0, 1'b0);
    at_state(193);
    chk("f1_blank1", an0, 3'b000);
    at_state(194);
    chk("f1_d0_an",   an0,   3'b001);
    chk("f1_d0_sseg", sseg0, 8'h3F);
    chk("al_d0_an",   an1,   3'b110);
    chk("al_d0_sseg", sseg1, 8'hC0);
    at_state(255);
    chk("f1_d0_end", an0, 3'b001);
    at_state(256);
    chk("f1_d1_blank", an0, 3'b000);
    at_state(258);
    chk("f1_d1_an",   an0,   3'b010);
    chk("f1_d1_sseg", sseg0, 8'h5B);
    at_state(322);
    chk("f1_d2_an",   an0,   3'b100);
    chk("f1_d2_sseg", sseg0, 8'h06);
    at_state(382);
    chk("tick_382", tick0, 1'b0);
    at_state(383);
    chk("tick_383", tick0, 1'b1);

    // bright=4: lit for cnt 2..15 only
    bright = 4'd4;
    at_state(385);
    chk("b4_cnt1",  an0, 3'b000);
    at_state(386);
    chk("b4_cnt2",  an0, 3'b001);
    at_state(399);
    chk("b4_cnt15", an0, 3'b001);
    at_state(400);
    chk("b4_cnt16", an0, 3'b000);
    at_state(447);
    chk("b4_cnt63", an0, 3'b000);

    // bright=0: fully dark
    bright = 4'd0;
    at_state(460);
    chk("b0_an", an0, 3'b000);
    at_state(470);
    chk("b0_an2",  an0,   3'b000);
    chk("b0_sseg", sseg0, 8'h00);

    // dig_en=101: digit 1 dark, others unchanged
    bright = 4'd15;
    dig_en = 3'b101;
    at_state(580);
    chk("en_d0_an",   an0,   3'b001);
    chk("en_d0_sseg", sseg0, 8'h3F);
    at_state(650);
    chk("en_d1_an",   an0,   3'b000);
    chk("en_d1_sseg", sseg0, 8'h00);
    at_state(714);
    chk("en_d2_an",   an0,   3'b100);
    chk("en_d2_sseg", sseg0, 8'h06);
    dig_en = 3'b111;

    // Mid-frame load: held back until next frame
    seg_in = {8'h4F, 8'h66, 8'h6D};
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    at_state(720);
    chk("mid_hold", sseg0, 8'h06);
    at_state(780);
    chk("mid_new_an",   an0,   3'b001);
    chk("mid_new_sseg", sseg0, 8'h6D);

    // Load exactly on the boundary cycle (state 959)
    at_state(958);
    chk("bnd_old", sseg0, 8'h4F);
    seg_in = {8'h7F, 8'h07, 8'h7D};
    load   = 1'b1;
    goto_cyc(960);
    load   = 1'b0;
    at_state(960);
    chk("bnd_blank", an0, 3'b000);
    at_state(962);
    chk("bnd_new_an",   an0,   3'b001);
    chk("bnd_new_sseg", sseg0, 8'h7D);

    // Asynchronous reset mid-slot on digit 2, with a load left pending
    at_state(1090);
    seg_in = {8'h11, 8'h22, 8'h33};
    load   = 1'b1;
    @(negedge clk);
    load   = 1'b0;
    at_state(1100);
    chk("pre_rst_an",   an0,   3'b100);
    chk("pre_rst_sseg", sseg0, 8'h7F);
    #2;
    reset_n = 1'b0;
    #1;
    chk("arst_an",     an0,   3'b000);
    chk("arst_sseg",   sseg0, 8'h00);
    chk("arst_an_al",  an1,   3'b111);
    chk("arst_seg_al", sseg1, 8'hFF);
    @(negedge clk);
    reset_n = 1'b1;

    // Restart from dig 0, cnt 0 with empty buffers
    at_state(1);
    chk("rs_blank", an0, 3'b000);
    at_state(5);
    chk("rs_d0_an",   an0,   3'b001);
    chk("rs_d0_sseg", sseg0, 8'h00);
    at_state(63);
    chk("rs_tick_63", tick0, 1'b0);
    at_state(190);
    chk("rs_tick_190", tick0, 1'b0);
    at_state(191);
    chk("rs_tick_191", tick0, 1'b1);
    at_state(194);
    chk("rs_disc_an",   an0,   3'b001);
    chk("rs_disc_sseg", sseg0, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
